// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int REG_ID_WIDTH = 5;

    localparam logic [REG_ID_WIDTH-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                    we;
        logic [REG_ID_WIDTH-1:0] rd_id;
        logic [DATA_WIDTH-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rf_wport_fifo.sv
// MDU result FIFO: circular pointers with a wrap bit, push into a full FIFO is
// legal only when a pop happens in the same cycle (caller guarantees this).
module rf_wport_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  wb_req_t i_din,
    input  logic    i_pop,
    output wb_req_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    wb_req_t     r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_ONE;
            if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB (priority) and queued MDU results, keeps
// the MDU destination scoreboard and the starvation counter.
// Optional macro WB_ARB_BYPASS_EN: same-cycle MDU writeback when FIFO empty and WB idle.
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  WB__ARB_regwrite,
    input  logic [4:0]            WB__ARB_rd_id,
    input  logic [DATA_WIDTH-1:0] WB__ARB_data,
    input  logic                  ID__ARB_mdu_issue,
    input  logic [4:0]            ID__ARB_mdu_rd_id,
    input  logic [4:0]            ID__ARB_rs1_id,
    input  logic [4:0]            ID__ARB_rs2_id,
    input  logic [4:0]            ID__ARB_rd_id,
    input  logic                  MDU__ARB_valid,
    input  logic [4:0]            MDU__ARB_rd_id,
    input  logic [DATA_WIDTH-1:0] MDU__ARB_data,
    output logic                  ARB__MDU_ready,
    output logic                  ARB__RF_we,
    output logic [4:0]            ARB__RF_rd_id,
    output logic [DATA_WIDTH-1:0] ARB__RF_data,
    output logic                  ARB__HZ_busy,
    output logic                  ARB__HZ_bubble
);

    import rf_wport_arbiter_pkg::*;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    wb_req_t     w_head;
    wb_req_t     w_mdu_req;
    wb_req_t     w_wr;
    logic        w_full;
    logic        w_empty;
    logic        w_wb_win;
    logic        w_push;
    logic        w_pop;
    logic        w_bypass;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_sb_rd;

    logic [31:0]   r_sb;
    logic [CW-1:0] r_starve;

    assign w_mdu_req = '{we: 1'b1, rd_id: MDU__ARB_rd_id, data: MDU__ARB_data};

    always_comb begin
        w_wb_win = WB__ARB_regwrite && (WB__ARB_rd_id != REG_ZERO);
        w_pop    = !w_empty && !w_wb_win;
`ifdef WB_ARB_BYPASS_EN
        w_bypass = w_empty && !w_wb_win && MDU__ARB_valid;
`else
        w_bypass = 1'b0;
`endif
        w_push   = MDU__ARB_valid && !w_full && !w_bypass;

        // A popped or bypassed result to x0 is consumed without a write.
        w_wr = '0;
        if (w_wb_win)
            w_wr = '{we: 1'b1, rd_id: WB__ARB_rd_id, data: WB__ARB_data};
        else if (w_pop && (w_head.rd_id != REG_ZERO))
            w_wr = w_head;
        else if (w_bypass && (MDU__ARB_rd_id != REG_ZERO))
            w_wr = w_mdu_req;
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (ID__ARB_mdu_issue && (ID__ARB_mdu_rd_id != REG_ZERO))
            w_set[ID__ARB_mdu_rd_id] = 1'b1;
        if (!w_wb_win && w_wr.we)
            w_clr[w_wr.rd_id] = 1'b1;
    end

    rf_wport_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_mdu_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb     <= '0;
            r_starve <= '0;
        end else begin
            // Set is applied after clear so a same-index reissue stays pending.
            r_sb <= (r_sb & ~w_clr) | w_set;
            if (w_empty || w_pop)
                r_starve <= '0;
            else if (w_wb_win && (r_starve != CNT_MAX))
                r_starve <= r_starve + CNT_ONE;
        end
    end

    assign w_sb_rd = {r_sb[31:1], 1'b0};

    assign ARB__MDU_ready = !w_full;
    assign ARB__RF_we     = w_wr.we;
    assign ARB__RF_rd_id  = w_wr.rd_id;
    assign ARB__RF_data   = w_wr.data;
    assign ARB__HZ_busy   = w_sb_rd[ID__ARB_rs1_id] | w_sb_rd[ID__ARB_rs2_id] |
                            w_sb_rd[ID__ARB_rd_id];
    assign ARB__HZ_bubble = (r_starve >= CNT_MAX);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Table-driven bench for rf_wport_arbiter; one vector per clock cycle.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WB__ARB_regwrite = 0;
    logic [4:0]  WB__ARB_rd_id = 0;
    logic [31:0] WB__ARB_data = 0;
    logic        ID__ARB_mdu_issue = 0;
    logic [4:0]  ID__ARB_mdu_rd_id = 0;
    logic [4:0]  ID__ARB_rs1_id = 0;
    logic [4:0]  ID__ARB_rs2_id = 0;
    logic [4:0]  ID__ARB_rd_id = 0;
    logic        MDU__ARB_valid = 0;
    logic [4:0]  MDU__ARB_rd_id = 0;
    logic [31:0] MDU__ARB_data = 0;
    logic        ARB__MDU_ready;
    logic        ARB__RF_we;
    logic [4:0]  ARB__RF_rd_id;
    logic [31:0] ARB__RF_data;
    logic        ARB__HZ_busy;
    logic        ARB__HZ_bubble;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4), .DATA_WIDTH(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .WB__ARB_regwrite  (WB__ARB_regwrite),
        .WB__ARB_rd_id     (WB__ARB_rd_id),
        .WB__ARB_data      (WB__ARB_data),
        .ID__ARB_mdu_issue (ID__ARB_mdu_issue),
        .ID__ARB_mdu_rd_id (ID__ARB_mdu_rd_id),
        .ID__ARB_rs1_id    (ID__ARB_rs1_id),
        .ID__ARB_rs2_id    (ID__ARB_rs2_id),
        .ID__ARB_rd_id     (ID__ARB_rd_id),
        .MDU__ARB_valid    (MDU__ARB_valid),
        .MDU__ARB_rd_id    (MDU__ARB_rd_id),
        .MDU__ARB_data     (MDU__ARB_data),
        .ARB__MDU_ready    (ARB__MDU_ready),
        .ARB__RF_we        (ARB__RF_we),
        .ARB__RF_rd_id     (ARB__RF_rd_id),
        .ARB__RF_data      (ARB__RF_data),
        .ARB__HZ_busy      (ARB__HZ_busy),
        .ARB__HZ_bubble    (ARB__HZ_bubble)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        iss;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  idrd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] edat;
        logic        erdy;
        logic        ebusy;
        logic        ebub;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic wr, input logic [4:0] wrd, input logic [31:0] wdat,
        input logic iss, input logic [4:0] ird,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] idrd,
        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
        input logic ewe, input logic [4:0] erd, input logic [31:0] edat,
        input logic erdy, input logic ebusy, input logic ebub);
        vec_t v;
        v.wr = wr;   v.wrd = wrd;   v.wdat = wdat;
        v.iss = iss; v.ird = ird;
        v.rs1 = rs1; v.rs2 = rs2;   v.idrd = idrd;
        v.mv = mv;   v.mrd = mrd;   v.mdat = mdat;
        v.ewe = ewe; v.erd = erd;   v.edat = edat;
        v.erdy = erdy; v.ebusy = ebusy; v.ebub = ebub;
        return v;
    endfunction

    function automatic logic [40:0] obs();
        return {ARB__RF_we, ARB__RF_rd_id, ARB__RF_data,
                ARB__MDU_ready, ARB__HZ_busy, ARB__HZ_bubble};
    endfunction

    task automatic chk(input string nm, input logic [40:0] act, input logic [40:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got we=%b rd=%0d data=%h rdy=%b busy=%b bub=%b, want we=%b rd=%0d data=%h rdy=%b busy=%b bub=%b",
                     nm, act[40], act[39:35], act[34:3], act[2], act[1], act[0],
                     exp[40], exp[39:35], exp[34:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input vec_t v);
        WB__ARB_regwrite  = v.wr;
        WB__ARB_rd_id     = v.wrd;
        WB__ARB_data      = v.wdat;
        ID__ARB_mdu_issue = v.iss;
        ID__ARB_mdu_rd_id = v.ird;
        ID__ARB_rs1_id    = v.rs1;
        ID__ARB_rs2_id    = v.rs2;
        ID__ARB_rd_id     = v.idrd;
        MDU__ARB_valid    = v.mv;
        MDU__ARB_rd_id    = v.mrd;
        MDU__ARB_data     = v.mdat;
    endtask

    task automatic idle();
        apply(mk(0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0));
    endtask

    initial begin
`ifndef WB_ARB_BYPASS_EN
        // issue rd5, observe busy, MDU result 1 cycle after acceptance
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   0,0,0,           0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0,        1,5,  5,0,0,   0,0,0,           0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  5,0,0,   0,0,0,           0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,        0,0,  5,0,0,   1,5,32'hDEADBEEF, 0,0,0,           1,1,0));
        tbl.push_back(mk(0,0,0,        0,0,  5,0,0,   0,0,0,           1,5,32'hDEADBEEF, 1,1,0));
        tbl.push_back(mk(0,0,0,        1,7,  5,0,0,   0,0,0,           0,0,0,            1,0,0));
        // WB hogs the port while rd7 waits: bubble after 4 losing cycles
        tbl.push_back(mk(1,3,32'h33,   0,0,  0,7,0,   1,7,32'h77,      1,3,32'h33,       1,1,0));
        tbl.push_back(mk(1,3,32'h34,   0,0,  0,7,0,   0,0,0,           1,3,32'h34,       1,1,0));
        tbl.push_back(mk(1,3,32'h35,   0,0,  0,7,0,   0,0,0,           1,3,32'h35,       1,1,0));
        tbl.push_back(mk(1,3,32'h36,   0,0,  0,7,0,   0,0,0,           1,3,32'h36,       1,1,0));
        tbl.push_back(mk(1,3,32'h37,   0,0,  0,7,0,   0,0,0,           1,3,32'h37,       1,1,0));
        tbl.push_back(mk(1,3,32'h38,   0,0,  0,7,0,   0,0,0,           1,3,32'h38,       1,1,1));
        tbl.push_back(mk(0,0,0,        0,0,  0,7,0,   0,0,0,           1,7,32'h77,       1,1,1));
        tbl.push_back(mk(0,0,0,        0,0,  0,7,0,   0,0,0,           0,0,0,            1,0,0));
        // fill to DEPTH=2, third result held until a pop, order kept
        tbl.push_back(mk(1,3,32'h40,   0,0,  0,0,0,   1,10,32'hA,      1,3,32'h40,       1,0,0));
        tbl.push_back(mk(1,3,32'h41,   0,0,  0,0,0,   1,11,32'hB,      1,3,32'h41,       1,0,0));
        tbl.push_back(mk(1,3,32'h42,   0,0,  0,0,0,   1,12,32'hC,      1,3,32'h42,       0,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   1,12,32'hC,      1,10,32'hA,       0,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   1,12,32'hC,      1,11,32'hB,       1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   0,0,0,           1,12,32'hC,       1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   0,0,0,           0,0,0,            1,0,0));
        // x0 handling: WB to x0 yields the port; MDU to x0 popped silently
        tbl.push_back(mk(1,0,32'h55,   0,0,  0,0,0,   1,13,32'hD,      0,0,0,            1,0,0));
        tbl.push_back(mk(1,0,32'h56,   0,0,  0,0,0,   0,0,0,           1,13,32'hD,       1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   1,0,32'hEE,      0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   0,0,0,           0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   1,15,32'hF,      0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   0,0,0,           1,15,32'hF,       1,0,0));
        // set and clear of the same scoreboard bit in one cycle: set wins
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   1,14,32'hE1,     0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0,        1,14, 14,0,0,  0,0,0,           1,14,32'hE1,      1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  14,0,0,  0,0,0,           0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,14,  0,0,0,           0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,        1,0,  0,0,0,   0,0,0,           0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   0,0,0,           0,0,0,            1,0,0));
`else
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   0,0,0,           0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   1,9,32'h1234,    1,9,32'h1234,     1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   0,0,0,           0,0,0,            1,0,0));
        tbl.push_back(mk(1,3,32'h50,   0,0,  0,0,0,   1,9,32'h99,      1,3,32'h50,       1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  0,0,0,   0,0,0,           1,9,32'h99,       1,0,0));
        tbl.push_back(mk(1,0,32'h51,   0,0,  0,0,0,   1,20,32'h20,     1,20,32'h20,      1,0,0));
        tbl.push_back(mk(0,0,0,        1,21, 0,0,0,   0,0,0,           0,0,0,            1,0,0));
        tbl.push_back(mk(0,0,0,        0,0,  21,0,0,  1,21,32'h21,     1,21,32'h21,      1,1,0));
        tbl.push_back(mk(0,0,0,        0,0,  21,0,0,  0,0,0,           0,0,0,            1,0,0));
`endif

        // reset state
        #2;
        chk("reset_idle", obs(), {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1 apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs(),
                {tbl[i].ewe, tbl[i].erd, tbl[i].edat, tbl[i].erdy, tbl[i].ebusy, tbl[i].ebub});
        end

        // reset while the FIFO is full: entries and scoreboard discarded at once
        @(posedge clk);
        #1 apply(mk(1,3,32'h1, 0,0, 0,0,0, 1,16,32'h16, 0,0,0, 0,0,0));
        @(posedge clk);
        #1 apply(mk(1,3,32'h2, 1,18, 0,0,0, 1,17,32'h17, 0,0,0, 0,0,0));
        @(posedge clk);
        #1 apply(mk(1,3,32'h3, 0,0, 18,0,0, 0,0,0, 0,0,0, 0,0,0));
        @(negedge clk);
        chk("full_before_rst", obs(), {1'b1, 5'd3, 32'h3, 1'b0, 1'b1, 1'b0});
        #1 idle();
        rst_n = 1'b0;
        #1;
        chk("midfill_rst", obs(), {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 apply(mk(0,0,0, 0,0, 14,18,0, 0,0,0, 0,0,0, 1,0,0));
        @(negedge clk);
        chk("after_rst_empty", obs(), {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the in-order WB stage and a multi-cycle execution unit (MDU: mul/div) that returns results out of band.
- Buffers MDU results in a small FIFO, keeps a destination-register scoreboard for issue-stage hazard checks, and requests a pipeline bubble when MDU results starve.
- Sits between WB/MDU and the register file and forwarding unit.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, at least 2)
- STARVE_LIMIT, 4, consecutive cycles a FIFO head may lose arbitration before a bubble is requested
- DATA_WIDTH, 32, write data width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- WB__ARB_regwrite  in  1  WB write request
- WB__ARB_rd_id  in  5  WB destination
- WB__ARB_data  in  DATA_WIDTH  WB write data
- ID__ARB_mdu_issue  in  1  MDU instruction issued this cycle
- ID__ARB_mdu_rd_id  in  5  destination of issued MDU instruction
- ID__ARB_rs1_id  in  5  issue-stage source 1
- ID__ARB_rs2_id  in  5  issue-stage source 2
- ID__ARB_rd_id  in  5  issue-stage destination
- MDU__ARB_valid  in  1  MDU result valid
- MDU__ARB_rd_id  in  5  MDU result destination
- MDU__ARB_data  in  DATA_WIDTH  MDU result
- ARB__MDU_ready  out  1  FIFO can accept a result
- ARB__RF_we  out  1  register-file write enable
- ARB__RF_rd_id  out  5  register-file write address
- ARB__RF_data  out  DATA_WIDTH  register-file write data
- ARB__HZ_busy  out  1  rs1, rs2 or rd of the issue stage is pending in the scoreboard
- ARB__HZ_bubble  out  1  request that the hazard unit insert one bubble, so that WB is empty the next cycle

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; scoreboard all 0; starve counter 0.
  - All outputs 0 except ARB__MDU_ready=1.
- MDU handshake:
  - A result is accepted when MDU__ARB_valid and ARB__MDU_ready are both 1.
  - ARB__MDU_ready = !full, registered-state based. It does not depend combinationally on MDU__ARB_valid.
  - The MDU holds valid and data until accepted.
- Arbitration (combinational output, one write per cycle):
  - WB has absolute priority when WB__ARB_regwrite=1 and WB__ARB_rd_id!=0.
  - Otherwise, if the FIFO is non-empty, the FIFO head is written and popped.
  - Otherwise ARB__RF_we=0.
  - Writes to x0 are never driven. A FIFO head with rd=0 is popped without asserting ARB__RF_we.
- Latency:
  - An accepted MDU result is written no earlier than the cycle after acceptance (base build).
- FIFO:
  - Circular pointers with one extra wrap bit; full/empty derived from the pointers.
  - Push and pop in the same cycle are allowed when full (pop frees the slot for the push; ready is still driven low when full).
- Scoreboard (32 bits):
  - ID__ARB_mdu_issue sets bit[mdu_rd_id] (ignored for rd 0).
  - A write of an MDU result clears its bit.
  - If set and clear hit the same index in the same cycle, set wins.
- ARB__HZ_busy:
  - Combinational OR of the scoreboard bits for rs1, rs2 and rd.
  - Bit 0 always reads 0.
  - The issue stage must not issue while busy; this blocks WAW ordering issues between WB and MDU writes.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and WB wins the port.
  - It resets to 0 on any FIFO pop or when the FIFO is empty.
  - ARB__HZ_bubble=1 while counter >= STARVE_LIMIT.
  - The counter saturates and never wraps.
- Reset mid-operation:
  - Pending FIFO entries and scoreboard bits are discarded.
  - The MDU is reset by the same rst_n.

Optional Feature:
- WB_ARB_BYPASS_EN defined:
  - When the FIFO is empty, WB is not writing, and MDU__ARB_valid=1, the MDU result is written to the RF in the same cycle.
  - It is not pushed into the FIFO, and its scoreboard bit is cleared that cycle.
  - Zero-latency writeback.
- Undefined:
  - Every MDU result passes through the FIFO, giving a minimum 1-cycle latency.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and REG_ID_WIDTH=5.
  - A wb_req struct type {we, rd_id, data}.
  - Constant REG_ZERO=5'd0.
- Sub-module: rf_wport_fifo (parameterised DEPTH FIFO of wb_req with push/pop/full/empty).
- Arbitration, scoreboard and starvation counter stay in the top module.

Test Plan:
- Reset, then check idle state:
  - Expect RF_we=0, MDU_ready=1, busy=0, bubble=0.
  - Assert rst_n mid-fill and check the FIFO empties immediately.
- Issue MDU rd=5; on the next cycle query rs1=5:
  - busy=1.
  - MDU returns 0xDEADBEEF to rd 5 with WB idle: RF write rd=5, data 0xDEADBEEF, 1 cycle after acceptance.
  - busy=0 afterwards.
- WB writes rd=3 continuously while an MDU result for rd=7 is queued:
  - WB wins every cycle.
  - bubble=1 after 4 cycles.
  - When WB goes idle, rd 7 is written and bubble returns to 0.
- Push three MDU results with WB busy (DEPTH=2):
  - ready drops to 0 after 2 pushes.
  - The third result is held, then accepted after a pop; write order is preserved.
- Zero-register handling:
  - WB regwrite with rd=0 produces RF_we=0 and lets a queued MDU result through.
  - An MDU result to rd 0 is popped silently.
- With WB_ARB_BYPASS_EN, FIFO empty, WB idle, MDU valid rd=9 data 0x1234:
  - RF write in the same cycle.
  - FIFO stays empty.
